exu_csr_arb: RTL and testbench

//  Sequencer and arbiter for the single CSR register-file port. Two requesters share it:
//  the EXU CSR path (ex) and the debug module (dbg).

---
 rtl/exu_csr_arb_pkg.sv | 31 +++
 rtl/exu_csr_rmw.sv | 23 ++
 rtl/exu_csr_arb.sv | 132 +++++++++++++
 tb/tb_exu_csr_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_csr_arb_pkg.sv
// Shared encodings for the CSR port arbiter: CSR op codes, one-hot sequencer states
// and requester identities.
package exu_csr_arb_pkg;

    localparam int CSR_OP_W = 2;

    typedef enum logic [CSR_OP_W-1:0] {
        OP_RD = 2'b00,
        OP_RW = 2'b01,
        OP_RS = 2'b10,
        OP_RC = 2'b11
    } csr_op_e;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RD   = 4'b0010,
        ST_WR   = 4'b0100,
        ST_RSP  = 4'b1000
    } arb_state_e;

    typedef enum logic {
        REQ_EX  = 1'b0,
        REQ_DBG = 1'b1
    } req_e;

    // Read-only accesses never touch the file on the write phase.
    function automatic logic op_writes(input logic [CSR_OP_W-1:0] op);
        return op != OP_RD;
    endfunction

endpackage

// File: rtl/exu_csr_rmw.sv
// Combinational read-modify-write merge of a CSR operand with the old CSR value.
module exu_csr_rmw
    import exu_csr_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [CSR_OP_W-1:0] op,
    input  logic [DW-1:0]       opn,
    input  logic [DW-1:0]       rdat,
    output logic [DW-1:0]       wdat
);

    always_comb begin
        wdat = rdat;
        case (op)
            OP_RW:   wdat = opn;
            OP_RS:   wdat = opn | rdat;
            OP_RC:   wdat = ~opn & rdat;
            default: wdat = rdat;
        endcase
    end

endmodule

// File: rtl/exu_csr_arb.sv
// Arbiter and read -> write -> respond sequencer for the single CSR file port,
// shared between the EXU CSR path (ex) and the debug module (dbg).
module exu_csr_arb
    import exu_csr_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int DBG_PRI = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hs_ex4ca_val,
    output logic                hs_ca4ex_rdy,
    input  logic [CSR_OP_W-1:0] ex_op,
    input  logic [AW-1:0]       ex_idx,
    input  logic [DW-1:0]       ex_opn,
    input  logic                ex_nowr,
    output logic                hs_ca4ex_rval,
    input  logic                hs_ex4ca_rrdy,
    output logic [DW-1:0]       ex_rdat,
    output logic                ex_err,
    input  logic                hs_db4ca_val,
    output logic                hs_ca4db_rdy,
    input  logic [CSR_OP_W-1:0] dbg_op,
    input  logic [AW-1:0]       dbg_idx,
    input  logic [DW-1:0]       dbg_opn,
    input  logic                dbg_nowr,
    output logic                hs_ca4db_rval,
    input  logic                hs_db4ca_rrdy,
    output logic [DW-1:0]       dbg_rdat,
    output logic                dbg_err,
    output logic                csr_ren,
    output logic                csr_wen,
    output logic [AW-1:0]       csr_idx,
    output logic [DW-1:0]       csr_wdat,
    input  logic [DW-1:0]       csr_rdat,
    input  logic                csr_ill
);

    arb_state_e          state_q, state_d;
    req_e                gnt_q, last_q, win;
    logic [CSR_OP_W-1:0] op_q;
    logic [AW-1:0]       idx_q;
    logic [DW-1:0]       opn_q, rdat_q, rmw_wdat;
    logic                nowr_q, ill_q;
    logic                idle, accept, rsp_rrdy;

    // On a tie either dbg wins outright, or the side that was not served last wins.
    always_comb begin
        win = REQ_EX;
        if (hs_ex4ca_val && hs_db4ca_val) begin
            if (DBG_PRI != 0) win = REQ_DBG;
            else              win = (last_q == REQ_EX) ? REQ_DBG : REQ_EX;
        end else if (hs_db4ca_val) begin
            win = REQ_DBG;
        end
    end

    assign idle         = (state_q == ST_IDLE) && !rst;
    assign hs_ca4ex_rdy = idle && hs_ex4ca_val && (win == REQ_EX);
    assign hs_ca4db_rdy = idle && hs_db4ca_val && (win == REQ_DBG);
    assign accept       = hs_ca4ex_rdy || hs_ca4db_rdy;
    assign rsp_rrdy     = (gnt_q == REQ_EX) ? hs_ex4ca_rrdy : hs_db4ca_rrdy;

    exu_csr_rmw #(.DW(DW)) u_rmw (
        .op   (op_q),
        .opn  (opn_q),
        .rdat (rdat_q),
        .wdat (rmw_wdat)
    );

    always_comb begin
        state_d  = state_q;
        csr_ren  = 1'b0;
        csr_wen  = 1'b0;
        csr_idx  = '0;
        csr_wdat = '0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD: begin
                csr_ren = 1'b1;
                csr_idx = idx_q;
                state_d = ST_WR;
            end
            ST_WR: begin
                csr_idx  = idx_q;
                csr_wdat = rmw_wdat;
                csr_wen  = !ill_q && !nowr_q && op_writes(op_q);
                state_d  = ST_RSP;
            end
            ST_RSP:  if (rsp_rrdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Illegal reads are zeroed at capture so the response never leaks file contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= REQ_EX;
            last_q  <= REQ_DBG;
            op_q    <= '0;
            idx_q   <= '0;
            opn_q   <= '0;
            nowr_q  <= 1'b0;
            rdat_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q  <= win;
                op_q   <= (win == REQ_DBG) ? dbg_op   : ex_op;
                idx_q  <= (win == REQ_DBG) ? dbg_idx  : ex_idx;
                opn_q  <= (win == REQ_DBG) ? dbg_opn  : ex_opn;
                nowr_q <= (win == REQ_DBG) ? dbg_nowr : ex_nowr;
            end
            if (state_q == ST_RD) begin
                rdat_q <= csr_ill ? '0 : csr_rdat;
                ill_q  <= csr_ill;
            end
            if (state_q == ST_RSP && rsp_rrdy) last_q <= gnt_q;
        end
    end

    assign hs_ca4ex_rval = (state_q == ST_RSP) && (gnt_q == REQ_EX);
    assign hs_ca4db_rval = (state_q == ST_RSP) && (gnt_q == REQ_DBG);
    assign ex_rdat       = hs_ca4ex_rval ? rdat_q : '0;
    assign dbg_rdat      = hs_ca4db_rval ? rdat_q : '0;
    assign ex_err        = hs_ca4ex_rval && ill_q;
    assign dbg_err       = hs_ca4db_rval && ill_q;

endmodule

// File: tb/tb_exu_csr_arb.sv
// Self-checking bench for exu_csr_arb: transaction-level model checked every cycle,
// directed scenarios with literal expectations, and a round-robin instance.
module tb_exu_csr_arb;
    import exu_csr_arb_pkg::*;

    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int DBG_PRI = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          ex_val = 0, ex_rdy, ex_nowr = 0, ex_rval, ex_rrdy = 1, ex_err;
    logic [1:0]    ex_op = 0;
    logic [AW-1:0] ex_idx = 0;
    logic [DW-1:0] ex_opn = 0, ex_rdat;
    logic          dbg_val = 0, dbg_rdy, dbg_nowr = 0, dbg_rval, dbg_rrdy = 1, dbg_err;
    logic [1:0]    dbg_op = 0;
    logic [AW-1:0] dbg_idx = 0;
    logic [DW-1:0] dbg_opn = 0, dbg_rdat;
    logic          csr_ren, csr_wen, csr_ill;
    logic [AW-1:0] csr_idx;
    logic [DW-1:0] csr_wdat, csr_rdat;

    exu_csr_arb #(.DW(DW), .AW(AW), .DBG_PRI(DBG_PRI)) u_dut (
        .clk(clk), .rst(rst),
        .hs_ex4ca_val(ex_val), .hs_ca4ex_rdy(ex_rdy), .ex_op(ex_op), .ex_idx(ex_idx),
        .ex_opn(ex_opn), .ex_nowr(ex_nowr), .hs_ca4ex_rval(ex_rval), .hs_ex4ca_rrdy(ex_rrdy),
        .ex_rdat(ex_rdat), .ex_err(ex_err),
        .hs_db4ca_val(dbg_val), .hs_ca4db_rdy(dbg_rdy), .dbg_op(dbg_op), .dbg_idx(dbg_idx),
        .dbg_opn(dbg_opn), .dbg_nowr(dbg_nowr), .hs_ca4db_rval(dbg_rval), .hs_db4ca_rrdy(dbg_rrdy),
        .dbg_rdat(dbg_rdat), .dbg_err(dbg_err),
        .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_idx(csr_idx), .csr_wdat(csr_wdat),
        .csr_rdat(csr_rdat), .csr_ill(csr_ill)
    );

    // Round-robin instance: both requesters permanently requesting, responses always taken.
    logic          rr_en = 0;
    logic          rr_ex_rdy, rr_ex_rval, rr_ex_err, rr_dbg_rdy, rr_dbg_rval, rr_dbg_err;
    logic          rr_ren, rr_wen;
    logic [AW-1:0] rr_idx;
    logic [DW-1:0] rr_wdat, rr_ex_rdat, rr_dbg_rdat;

    exu_csr_arb #(.DW(DW), .AW(AW), .DBG_PRI(0)) u_rr (
        .clk(clk), .rst(rst),
        .hs_ex4ca_val(rr_en), .hs_ca4ex_rdy(rr_ex_rdy), .ex_op(2'b01), .ex_idx(12'h001),
        .ex_opn(32'h1), .ex_nowr(1'b0), .hs_ca4ex_rval(rr_ex_rval), .hs_ex4ca_rrdy(1'b1),
        .ex_rdat(rr_ex_rdat), .ex_err(rr_ex_err),
        .hs_db4ca_val(rr_en), .hs_ca4db_rdy(rr_dbg_rdy), .dbg_op(2'b01), .dbg_idx(12'h002),
        .dbg_opn(32'h2), .dbg_nowr(1'b0), .hs_ca4db_rval(rr_dbg_rval), .hs_db4ca_rrdy(1'b1),
        .dbg_rdat(rr_dbg_rdat), .dbg_err(rr_dbg_err),
        .csr_ren(rr_ren), .csr_wen(rr_wen), .csr_idx(rr_idx), .csr_wdat(rr_wdat),
        .csr_rdat(32'h0), .csr_ill(1'b0)
    );

    // CSR file: combinational read, 0xFFF is the one illegal index.
    logic [DW-1:0] fmem [0:4095];
    logic          pl_en = 0;
    logic [AW-1:0] pl_idx = 0;
    logic [DW-1:0] pl_dat = 0;
    assign csr_rdat = fmem[csr_idx];
    assign csr_ill  = (csr_idx == 12'hFFF);
    always @(posedge clk) begin
        if (pl_en)   fmem[pl_idx]  <= pl_dat;
        if (csr_wen) fmem[csr_idx] <= csr_wdat;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: stage 0 idle, 1 read, 2 write, 3 respond.
    logic [DW-1:0] ref_mem [0:4095];
    int            stage = 0, m_who = 0, m_last = 1, mon_w = 0, rsp_cnt = 0, m_hold = 0;
    logic [1:0]    m_op;
    logic [AW-1:0] m_idx;
    logic [DW-1:0] m_opn, m_old, m_wdat;
    logic          m_nowr, m_ill, m_wen;
    int            t_acc = 0, t_ren = 0, t_wen = -1, t_rval = -1, acc_ex = 0, acc_dbg = 0, done_cyc = 0;
    logic [DW-1:0] t_wdat = 0, t_rdat = 0;
    logic          t_err = 0;

    always @(negedge clk) begin
        if (pl_en) ref_mem[pl_idx] = pl_dat;
        if (rst) begin
            checkOutput("rst_quiet", 64'({ex_rdy, dbg_rdy, ex_rval, dbg_rval, ex_err, dbg_err, csr_ren, csr_wen}), 64'(0));
            stage  = 0;
            m_last = 1;
        end else begin
            checkOutput("ren_wen_excl", 64'(csr_ren & csr_wen), 64'(0));
            case (stage)
                0: begin
                    if (ex_val && dbg_val) mon_w = (DBG_PRI != 0) ? 1 : 1 - m_last;
                    else                   mon_w = dbg_val ? 1 : 0;
                    checkOutput("rdy_ex", 64'(ex_rdy), 64'(ex_val && mon_w == 0));
                    checkOutput("rdy_dbg", 64'(dbg_rdy), 64'(dbg_val && mon_w == 1));
                    checkOutput("idle_quiet", 64'({ex_rval, dbg_rval, csr_ren, csr_wen}), 64'(0));
                    checkOutput("idle_idx", 64'(csr_idx), 64'(0));
                    if (ex_val || dbg_val) begin
                        m_who  = mon_w;
                        m_op   = (m_who == 1) ? dbg_op   : ex_op;
                        m_idx  = (m_who == 1) ? dbg_idx  : ex_idx;
                        m_opn  = (m_who == 1) ? dbg_opn  : ex_opn;
                        m_nowr = (m_who == 1) ? dbg_nowr : ex_nowr;
                        m_ill  = (m_idx == 12'hFFF);
                        m_old  = m_ill ? 32'h0 : ref_mem[m_idx];
                        m_wen  = !m_ill && !m_nowr && (m_op != 2'b00);
                        case (m_op)
                            2'b01:   m_wdat = m_opn;
                            2'b10:   m_wdat = m_opn | m_old;
                            2'b11:   m_wdat = ~m_opn & m_old;
                            default: m_wdat = m_old;
                        endcase
                        t_acc = cyc; t_wen = -1; t_rval = -1; rsp_cnt = 0;
                        if (m_who == 0) acc_ex = cyc; else acc_dbg = cyc;
                        stage = 1;
                    end
                end
                1: begin
                    checkOutput("rd_ren", 64'(csr_ren), 64'(1));
                    checkOutput("rd_idx", 64'(csr_idx), 64'(m_idx));
                    checkOutput("busy_rdy", 64'({ex_rdy, dbg_rdy, ex_rval, dbg_rval}), 64'(0));
                    t_ren = cyc;
                    stage = 2;
                end
                2: begin
                    checkOutput("wr_ren", 64'(csr_ren), 64'(0));
                    checkOutput("wr_wen", 64'(csr_wen), 64'(m_wen));
                    if (m_wen) begin
                        checkOutput("wr_wdat", 64'(csr_wdat), 64'(m_wdat));
                        checkOutput("wr_idx", 64'(csr_idx), 64'(m_idx));
                        ref_mem[m_idx] = m_wdat;
                    end
                    checkOutput("busy_rdy", 64'({ex_rdy, dbg_rdy, ex_rval, dbg_rval}), 64'(0));
                    if (csr_wen) begin t_wen = cyc; t_wdat = csr_wdat; end
                    stage = 3;
                end
                default: begin
                    checkOutput("rsp_rval", 64'({ex_rval, dbg_rval}), 64'((m_who == 1) ? 2'b01 : 2'b10));
                    checkOutput("rsp_rdat", 64'((m_who == 1) ? dbg_rdat : ex_rdat), 64'(m_old));
                    checkOutput("rsp_err", 64'((m_who == 1) ? dbg_err : ex_err), 64'(m_ill));
                    checkOutput("rsp_quiet", 64'({ex_rdy, dbg_rdy, csr_ren, csr_wen}), 64'(0));
                    checkOutput("rsp_idx", 64'(csr_idx), 64'(0));
                    if (t_rval < 0) begin
                        t_rval = cyc;
                        t_rdat = (m_who == 1) ? dbg_rdat : ex_rdat;
                        t_err  = (m_who == 1) ? dbg_err : ex_err;
                    end
                    if ((m_who == 1) ? dbg_rrdy : ex_rrdy) begin
                        m_hold = cyc - t_rval; m_last = m_who; done_cyc = cyc; stage = 0;
                    end else begin
                        rsp_cnt++;
                    end
                end
            endcase
        end
    end

    int rr_order [$];
    always @(negedge clk) begin
        if (!rst && rr_ex_rdy && rr_dbg_rdy) checkOutput("rr_both_rdy", 64'(1), 64'(0));
        if (!rst && rr_ex_rdy)  rr_order.push_back(0);
        if (!rst && rr_dbg_rdy) rr_order.push_back(1);
    end

    task automatic preload(input logic [AW-1:0] idx, input logic [DW-1:0] dat);
        pl_en = 1; pl_idx = idx; pl_dat = dat;
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic applyStimulus(input int who, input logic [1:0] op, input logic [AW-1:0] idx,
                                 input logic [DW-1:0] opn, input logic nowr);
        bit ok = 0;
        if (who == 0) begin ex_val = 1; ex_op = op; ex_idx = idx; ex_opn = opn; ex_nowr = nowr; end
        else begin dbg_val = 1; dbg_op = op; dbg_idx = idx; dbg_opn = opn; dbg_nowr = nowr; end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if ((who == 0) ? ex_rdy : dbg_rdy) ok = 1;
            @(posedge clk); #1;
        end
        if (who == 0) ex_val = 0; else dbg_val = 0;
        if (!ok) checkOutput("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic waitDone();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (stage == 0) ok = 1;
        end
        if (!ok) checkOutput("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ex_val = 1; dbg_val = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdy", 64'({ex_rdy, dbg_rdy}), 64'(0));
        checkOutput("reset_strobes", 64'({csr_ren, csr_wen, ex_rval, dbg_rval}), 64'(0));
        ex_val = 0; dbg_val = 0;
        @(posedge clk); #1;
        rst = 0;

        // Basic RW with timing
        preload(12'h340, 32'h1234);
        applyStimulus(0, 2'b01, 12'h340, 32'hDEAD_BEEF, 0);
        waitDone();
        checkOutput("t1_ren_lat", 64'(t_ren - t_acc), 64'(1));
        checkOutput("t1_wen_lat", 64'(t_wen - t_acc), 64'(2));
        checkOutput("t1_rval_lat", 64'(t_rval - t_acc), 64'(3));
        checkOutput("t1_wdat", 64'(t_wdat), 64'h0000_0000_DEAD_BEEF);
        checkOutput("t1_rdat", 64'(t_rdat), 64'h1234);
        checkOutput("t1_file", 64'(fmem[12'h340]), 64'hDEAD_BEEF);

        // Set, clear, suppressed write
        preload(12'h341, 32'hF0);
        applyStimulus(0, 2'b10, 12'h341, 32'h0F, 0);
        waitDone();
        checkOutput("t2_rs_wdat", 64'(t_wdat), 64'hFF);
        applyStimulus(0, 2'b11, 12'h341, 32'h30, 0);
        waitDone();
        checkOutput("t2_rc_wdat", 64'(t_wdat), 64'hCF);
        applyStimulus(0, 2'b10, 12'h341, 32'hFF, 1);
        waitDone();
        checkOutput("t2_nowr_wen", 64'(t_wen), 64'(-1));
        checkOutput("t2_nowr_rdat", 64'(t_rdat), 64'hCF);
        checkOutput("t2_file", 64'(fmem[12'h341]), 64'hCF);

        // Illegal index
        applyStimulus(0, 2'b01, 12'hFFF, 32'h1111, 0);
        waitDone();
        checkOutput("t4_wen", 64'(t_wen), 64'(-1));
        checkOutput("t4_err", 64'(t_err), 64'(1));
        checkOutput("t4_rdat", 64'(t_rdat), 64'(0));

        // Simultaneous requests: dbg first, ex four cycles later and sees dbg's write
        preload(12'h342, 32'h5);
        fork
            applyStimulus(0, 2'b10, 12'h342, 32'h10, 0);
            applyStimulus(1, 2'b01, 12'h342, 32'hA0, 0);
        join
        waitDone();
        checkOutput("t3_gap", 64'(acc_ex - acc_dbg), 64'(4));
        checkOutput("t3_ex_rdat", 64'(t_rdat), 64'hA0);
        checkOutput("t3_file", 64'(fmem[12'h342]), 64'hB0);

        // Response back-pressure with dbg waiting
        ex_rrdy = 0;
        applyStimulus(0, 2'b00, 12'h342, 32'h0, 0);
        fork
            applyStimulus(1, 2'b00, 12'h341, 32'h0, 0);
            begin
                for (int i = 0; i < 50 && rsp_cnt < 5; i++) begin @(posedge clk); #1; end
                ex_rrdy = 1;
            end
        join
        checkOutput("t5_hold", 64'(m_hold), 64'(5));
        checkOutput("t5_next_accept", 64'(acc_dbg - done_cyc), 64'(1));
        waitDone();
        checkOutput("t5_dbg_rdat", 64'(t_rdat), 64'hCF);

        // Reset during the write phase
        preload(12'h343, 32'h77);
        applyStimulus(0, 2'b01, 12'h343, 32'h99, 0);
        @(posedge clk); #1;
        checkOutput("t6_wen_pre", 64'(csr_wen), 64'(1));
        rst = 1;
        #1;
        checkOutput("t6_wen_drop", 64'({csr_wen, ex_rval}), 64'(0));
        @(posedge clk); #1;
        rst = 0;
        checkOutput("t6_no_write", 64'(fmem[12'h343]), 64'h77);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6_no_rval", 64'({ex_rval, dbg_rval}), 64'(0));
        applyStimulus(0, 2'b01, 12'h343, 32'h99, 0);
        waitDone();
        checkOutput("t6_rdat", 64'(t_rdat), 64'h77);
        checkOutput("t6_file", 64'(fmem[12'h343]), 64'h99);

        // Round-robin alternation, starting with ex because last resets to dbg
        rr_order.delete();
        rr_en = 1;
        for (int i = 0; i < 200 && rr_order.size() < 8; i++) begin @(posedge clk); #1; end
        rr_en = 0;
        checkOutput("rr_count", 64'(rr_order.size() >= 8), 64'(1));
        for (int i = 0; i < 8 && i < rr_order.size(); i++)
            checkOutput($sformatf("rr_order_%0d", i), 64'(rr_order[i]), 64'(i % 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
